// File: rtl/ufm_pkg.sv
// Shared constants and fetcher state encoding for the UFM page fetcher.
package ufm_pkg;

  localparam int unsigned UFM_PAGE_ADDR_W = 11;
  localparam int unsigned UFM_PAGE_BYTES  = 16;
  localparam int unsigned UFM_MAX_PAGES   = 2048;
  localparam int unsigned UFM_PAGE_CNT_W  = $clog2(UFM_MAX_PAGES) + 1;
  localparam int unsigned UFM_BYTE_CNT_W  = $clog2(UFM_PAGE_BYTES);
  localparam int unsigned UFM_BYTE_W      = 8;

  localparam int unsigned FETCH_STATE_W = 3;
  typedef logic [FETCH_STATE_W-1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE       = 3'd0;
  localparam fetch_state_t ST_WAIT_SPACE = 3'd1;
  localparam fetch_state_t ST_ISSUE      = 3'd2;
  localparam fetch_state_t ST_COLLECT    = 3'd3;
  localparam fetch_state_t ST_WAIT_IDLE  = 3'd4;
  localparam fetch_state_t ST_DRAIN      = 3'd5;

endpackage

// File: rtl/ufm_page_fetcher_if.sv
// Streamer-side and downstream byte-stream signals of the page fetcher.
// UFM_PAGE_FETCHER_LAST_EN adds m_last to the stream.
interface ufm_page_fetcher_if;
  import ufm_pkg::*;

  logic                       ufm_start;
  logic [UFM_PAGE_ADDR_W-1:0] ufm_page_addr;
  logic                       ufm_ready;
  logic                       ufm_rd_stb;
  logic [UFM_BYTE_W-1:0]      ufm_data_rd;
  logic [UFM_BYTE_W-1:0]      m_data;
  logic                       m_valid;
  logic                       m_ready;
`ifdef UFM_PAGE_FETCHER_LAST_EN
  logic                       m_last;
`endif

  modport master (
    output ufm_start, ufm_page_addr, m_data, m_valid,
`ifdef UFM_PAGE_FETCHER_LAST_EN
    output m_last,
`endif
    input  ufm_ready, ufm_rd_stb, ufm_data_rd, m_ready
  );

  modport slave (
    input  ufm_start, ufm_page_addr, m_data, m_valid,
`ifdef UFM_PAGE_FETCHER_LAST_EN
    input  m_last,
`endif
    output ufm_ready, ufm_rd_stb, ufm_data_rd, m_ready
  );

endinterface

// File: rtl/ufm_byte_fifo.sv
// Synchronous FIFO with occupancy count; head entry is presented directly.
module ufm_byte_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Qualify requests; a push at full only lands when a pop frees the slot.
  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/ufm_page_fetcher.sv
// Walks a range of UFM pages through the streamer and re-emits the bytes
// as a valid/ready stream. UFM_PAGE_FETCHER_LAST_EN adds m_last.
module ufm_page_fetcher
  import ufm_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned PAGE_BYTES = UFM_PAGE_BYTES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic [UFM_PAGE_ADDR_W-1:0] first_page,
  input  logic [UFM_PAGE_CNT_W-1:0]  num_pages,
  output logic                       busy,
  output logic                       done,
  ufm_page_fetcher_if.master         bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef UFM_PAGE_FETCHER_LAST_EN
  localparam int unsigned FIFO_W = UFM_BYTE_W + 1;
`else
  localparam int unsigned FIFO_W = UFM_BYTE_W;
`endif

  fetch_state_t               state_q, state_d;
  logic [UFM_PAGE_ADDR_W-1:0] first_q;
  logic [UFM_PAGE_CNT_W-1:0]  num_q;
  logic [UFM_PAGE_CNT_W-1:0]  page_idx_q;
  logic [UFM_BYTE_CNT_W-1:0]  byte_cnt_q;
  logic                       busy_d, done_d, start_d;

  logic                       push, pop, space_ok, last_byte, last_page;
  logic [CNT_W-1:0]           fifo_count, occ_after_pop;
  logic [FIFO_W-1:0]          fifo_din, fifo_dout;

  // Handshake and page-progress decode.
  always_comb begin
    pop           = bus.m_valid && bus.m_ready;
    push          = (state_q == ST_COLLECT) && bus.ufm_rd_stb;
    occ_after_pop = fifo_count - CNT_W'(pop);
    space_ok      = occ_after_pop <= CNT_W'(FIFO_DEPTH - PAGE_BYTES);
    last_byte     = push && (byte_cnt_q == UFM_BYTE_CNT_W'(PAGE_BYTES - 1));
    last_page     = (page_idx_q + UFM_PAGE_CNT_W'(1)) == num_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (go && (num_pages != '0)) state_d = ST_WAIT_SPACE;
      ST_WAIT_SPACE: if (space_ok && bus.ufm_ready) state_d = ST_ISSUE;
      ST_ISSUE:      state_d = ST_COLLECT;
      ST_COLLECT:    if (last_byte) state_d = ST_WAIT_IDLE;
      ST_WAIT_IDLE:  if (bus.ufm_ready) state_d = last_page ? ST_DRAIN : ST_WAIT_SPACE;
      ST_DRAIN:      if (fifo_count == '0) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Output decode, fed to the output registers below.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    start_d = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    start_d = (state_d == ST_ISSUE);
    done_d  = ((state_q == ST_IDLE) && go && (num_pages == '0)) ||
              ((state_q == ST_DRAIN) && (state_d == ST_IDLE));
  end

  // Run context, counters and registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      first_q           <= '0;
      num_q             <= '0;
      page_idx_q        <= '0;
      byte_cnt_q        <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      bus.ufm_start     <= 1'b0;
      bus.ufm_page_addr <= '0;
    end else begin
      busy          <= busy_d;
      done          <= done_d;
      bus.ufm_start <= start_d;
      if ((state_q == ST_IDLE) && go && (num_pages != '0)) begin
        first_q    <= first_page;
        num_q      <= num_pages;
        page_idx_q <= '0;
      end
      // Address wraps at the 11-bit page space.
      if ((state_q == ST_WAIT_SPACE) && (state_d == ST_ISSUE))
        bus.ufm_page_addr <= first_q + UFM_PAGE_ADDR_W'(page_idx_q);
      if (state_q == ST_ISSUE) byte_cnt_q <= '0;
      else if (push)           byte_cnt_q <= byte_cnt_q + UFM_BYTE_CNT_W'(1);
      if ((state_q == ST_WAIT_IDLE) && bus.ufm_ready)
        page_idx_q <= page_idx_q + UFM_PAGE_CNT_W'(1);
    end
  end

`ifdef UFM_PAGE_FETCHER_LAST_EN
  assign fifo_din   = {last_byte && last_page, bus.ufm_data_rd};
  assign bus.m_data = fifo_dout[UFM_BYTE_W-1:0];
  assign bus.m_last = fifo_dout[UFM_BYTE_W];
`else
  assign fifo_din   = bus.ufm_data_rd;
  assign bus.m_data = fifo_dout;
`endif

  ufm_byte_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (bus.m_valid),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_ufm_page_fetcher.sv
// Directed bench for ufm_page_fetcher with a simple streamer model and sink
// monitor. Checks m_last when UFM_PAGE_FETCHER_LAST_EN is defined.
module tb_ufm_page_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [10:0] first_page;
  logic [11:0] num_pages;
  logic        busy;
  logic        done;

  ufm_page_fetcher_if bus_if ();

  ufm_page_fetcher #(.FIFO_DEPTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .first_page (first_page),
    .num_pages  (num_pages),
    .busy       (busy),
    .done       (done),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Monitor state (written only by the monitor / streamer processes).
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_pop_cyc = 0;
  int          start_cnt = 0;
  logic [7:0]  out_q[$];
  logic        last_q[$];
  logic [10:0] addr_q[$];

  // Per-test bases (written only by the main process).
  int seq_base = 0;
  int out_base = 0;
  int addr_base = 0;
  int done_base = 0;
  int stray_end = 0;

  // Sink monitor: records popped bytes and done pulses.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      if (bus_if.m_valid && bus_if.m_ready) begin
        out_q.push_back(bus_if.m_data);
`ifdef UFM_PAGE_FETCHER_LAST_EN
        last_q.push_back(bus_if.m_last);
`else
        last_q.push_back(1'b0);
`endif
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  // Streamer model: one idle cycle after start, then 16 byte strobes.
  // Byte value = (page number within the test)*16 + byte index.
  initial begin
    bus_if.ufm_ready   = 1'b1;
    bus_if.ufm_rd_stb  = 1'b0;
    bus_if.ufm_data_rd = 8'h00;
    forever begin
      @(negedge clk);
      if (rst && bus_if.ufm_start) begin
        addr_q.push_back(bus_if.ufm_page_addr);
        start_cnt = start_cnt + 1;
        bus_if.ufm_ready = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 16; b++) begin
          if (!rst) break;
          bus_if.ufm_rd_stb  = 1'b1;
          bus_if.ufm_data_rd = 8'((start_cnt - 1 - seq_base) * 16 + b);
          @(negedge clk);
        end
        bus_if.ufm_rd_stb = 1'b0;
        bus_if.ufm_ready  = 1'b1;
      end else if (cyc < stray_end) begin
        bus_if.ufm_rd_stb  = 1'b1;
        bus_if.ufm_data_rd = 8'hAA;
      end else begin
        bus_if.ufm_rd_stb = 1'b0;
      end
    end
  end

  task automatic begin_test();
    seq_base  = start_cnt;
    out_base  = out_q.size();
    addr_base = addr_q.size();
    done_base = done_cnt;
  endtask

  task automatic start_run(input logic [10:0] fp, input logic [11:0] np);
    @(posedge clk); #1;
    go = 1'b1; first_page = fp; num_pages = np;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while ((done_cnt == done_base) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (done_cnt == done_base) begin
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", bound);
    end
  endtask

  task automatic check_bytes(input string name, input int nbytes, input int last_idx);
    n_cmp++;
    if (out_q.size() - out_base != nbytes) begin
      n_err++;
      $display("FAIL %s_count: got %0d bytes, expected %0d", name, out_q.size() - out_base, nbytes);
    end else begin
      for (int i = 0; i < nbytes; i++) begin
        n_cmp++;
        if (out_q[out_base + i] !== 8'(i)) begin
          n_err++;
          $display("FAIL %s_byte%0d: got %h, expected %h", name, i, out_q[out_base + i], 8'(i));
        end
`ifdef UFM_PAGE_FETCHER_LAST_EN
        n_cmp++;
        if (last_q[out_base + i] !== (i == last_idx)) begin
          n_err++;
          $display("FAIL %s_last%0d: got %b, expected %b", name, i, last_q[out_base + i], (i == last_idx));
        end
`endif
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; go = 1'b0; first_page = '0; num_pages = '0;
    bus_if.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b, expected 0", done); end
    n_cmp++; if (bus_if.ufm_start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b, expected 0", bus_if.ufm_start); end
    n_cmp++; if (bus_if.ufm_page_addr !== 11'h000) begin n_err++; $display("FAIL rst_addr: got %h, expected 000", bus_if.ufm_page_addr); end
    n_cmp++; if (bus_if.m_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, expected 0", bus_if.m_valid); end
    n_cmp++; if (bus_if.m_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h, expected 00", bus_if.m_data); end
    rst = 1'b1;
  endtask

  task automatic test_single_page();
    begin_test();
    bus_if.m_ready = 1'b1;
    start_run(11'h005, 12'd1);
    wait_done(400);
    n_cmp++; if (start_cnt - seq_base != 1) begin n_err++; $display("FAIL single_starts: got %0d, expected 1", start_cnt - seq_base); end
    n_cmp++; if (addr_q.size() <= addr_base || addr_q[addr_base] !== 11'h005) begin n_err++; $display("FAIL single_addr: expected 005, log size %0d", addr_q.size() - addr_base); end
    check_bytes("single", 16, 15);
    n_cmp++; if (done_cyc != last_pop_cyc + 2) begin n_err++; $display("FAIL single_done_timing: done at %0d, expected %0d", done_cyc, last_pop_cyc + 2); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_at_done: got %b, expected 0", busy); end
  endtask

  task automatic test_wrap();
    logic [10:0] exp_addr [3];
    exp_addr[0] = 11'h7FE; exp_addr[1] = 11'h7FF; exp_addr[2] = 11'h000;
    begin_test();
    bus_if.m_ready = 1'b1;
    start_run(11'h7FE, 12'd3);
    wait_done(800);
    n_cmp++; if (start_cnt - seq_base != 3) begin n_err++; $display("FAIL wrap_starts: got %0d, expected 3", start_cnt - seq_base); end
    for (int p = 0; p < 3; p++) begin
      n_cmp++;
      if (addr_q.size() <= addr_base + p || addr_q[addr_base + p] !== exp_addr[p]) begin
        n_err++;
        $display("FAIL wrap_addr%0d: expected %h, log size %0d", p, exp_addr[p], addr_q.size() - addr_base);
      end
    end
    check_bytes("wrap", 48, 47);
  endtask

  task automatic test_backpressure();
    begin_test();
    bus_if.m_ready = 1'b0;
    start_run(11'h100, 12'd4);
    repeat (200) @(negedge clk);
    n_cmp++; if (start_cnt - seq_base != 2) begin n_err++; $display("FAIL bp_stall_starts: got %0d, expected 2", start_cnt - seq_base); end
    n_cmp++; if (dut.u_fifo.count !== 6'd32) begin n_err++; $display("FAIL bp_fifo_count: got %0d, expected 32", dut.u_fifo.count); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy: got %b, expected 1", busy); end
    n_cmp++; if (bus_if.m_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b, expected 1", bus_if.m_valid); end
    n_cmp++; if (bus_if.m_data !== 8'h00) begin n_err++; $display("FAIL bp_hold_data: got %h, expected 00", bus_if.m_data); end
    @(posedge clk); #1;
    bus_if.m_ready = 1'b1;
    wait_done(800);
    n_cmp++; if (start_cnt - seq_base != 4) begin n_err++; $display("FAIL bp_starts: got %0d, expected 4", start_cnt - seq_base); end
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (addr_q.size() <= addr_base + p || addr_q[addr_base + p] !== 11'(11'h100 + p)) begin
        n_err++;
        $display("FAIL bp_addr%0d: expected %h, log size %0d", p, 11'(11'h100 + p), addr_q.size() - addr_base);
      end
    end
    check_bytes("bp", 64, 63);
  endtask

  task automatic test_zero_pages();
    begin_test();
    @(posedge clk); #1;
    go = 1'b1; first_page = 11'h033; num_pages = 12'd0;
    @(posedge clk); #1;
    go = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b, expected 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b, expected 0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_pulse: got %b, expected 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_after: got %b, expected 0", busy); end
    repeat (5) @(negedge clk);
    n_cmp++; if (start_cnt != seq_base) begin n_err++; $display("FAIL zero_starts: got %0d, expected 0", start_cnt - seq_base); end
  endtask

  task automatic test_stray_stb();
    begin_test();
    stray_end = cyc + 4;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus_if.m_valid !== 1'b0) begin n_err++; $display("FAIL stray_valid%0d: got %b, expected 0", i, bus_if.m_valid); end
    end
    n_cmp++; if (dut.u_fifo.count !== 6'd0) begin n_err++; $display("FAIL stray_count: got %0d, expected 0", dut.u_fifo.count); end
    n_cmp++; if (out_q.size() != out_base) begin n_err++; $display("FAIL stray_pops: got %0d, expected 0", out_q.size() - out_base); end
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    begin_test();
    bus_if.m_ready = 1'b1;
    start_run(11'h010, 12'd3);
    while ((start_cnt - seq_base < 2) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (start_cnt - seq_base < 2) begin n_err++; $display("FAIL midrst_page2: got %0d starts, expected 2", start_cnt - seq_base); end
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
    n_cmp++; if (bus_if.m_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b, expected 0", bus_if.m_valid); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b, expected 0", done); end
    n_cmp++; if (bus_if.ufm_start !== 1'b0) begin n_err++; $display("FAIL midrst_start: got %b, expected 0", bus_if.ufm_start); end
    rst = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (done_cnt != done_base) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses, expected 0", done_cnt - done_base); end
    begin_test();
    start_run(11'h020, 12'd1);
    wait_done(400);
    n_cmp++; if (start_cnt - seq_base != 1) begin n_err++; $display("FAIL restart_starts: got %0d, expected 1", start_cnt - seq_base); end
    n_cmp++; if (addr_q.size() <= addr_base || addr_q[addr_base] !== 11'h020) begin n_err++; $display("FAIL restart_addr: expected 020, log size %0d", addr_q.size() - addr_base); end
    check_bytes("restart", 16, 15);
  endtask

  initial begin
    test_reset();
    test_single_page();
    test_wrap();
    test_backpressure();
    test_zero_pages();
    test_stray_stb();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ufm_page_fetcher.md
Name: ufm_page_fetcher

Overview:
- Sits directly upstream of the UFM streamer.
- Drives the streamer's start/page_addr inputs and walks a contiguous range of UFM pages, one streamer transaction per page.
- Captures the 16 bytes of each page into an internal byte FIFO and presents them downstream as a byte stream with a valid/ready handshake.
- The streamer cannot be stalled, so a page is issued only when the FIFO has room for a whole page.

Parameters:
- FIFO_DEPTH, 32, byte FIFO depth. Power of two, ≥16.
- PAGE_BYTES, 16, bytes per UFM page. Fixed by the UFM read command; not to be overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-low.
- go  in  1  start a fetch run. Sampled only in IDLE.
- first_page  in  11  first UFM page address. Latched on accepted go.
- num_pages  in  12  number of pages, 0..2048. Latched on accepted go.
- busy  out  1  run in progress, including FIFO drain.
- done  out  1  one-cycle pulse at end of run.
- ufm_start  out  1  to streamer start.
- ufm_page_addr  out  11  to streamer page_addr. Held stable from ufm_start until the page completes.
- ufm_ready  in  1  from streamer ready.
- ufm_rd_stb  in  1  from streamer; byte strobe.
- ufm_data_rd  in  8  from streamer; byte, valid with ufm_rd_stb.
- m_data  out  8  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.

Behaviour:
- Reset (rst low at clk edge):
  - FSM to IDLE; FIFO emptied; page and byte counters cleared.
  - All outputs 0: busy, done, ufm_start, ufm_page_addr, m_valid, m_data.
  - Reset mid-run aborts the run with no done pulse. The streamer shares rst and restarts too.
- States: IDLE, WAIT_SPACE, ISSUE, COLLECT, WAIT_IDLE, DRAIN.
- IDLE:
  - go=1 with num_pages≠0: latch first_page and num_pages, set page_idx=0, go to WAIT_SPACE, busy=1 next cycle.
  - go=1 with num_pages=0: done pulses the next cycle; stay IDLE; busy stays 0.
- WAIT_SPACE: when FIFO free ≥ PAGE_BYTES (count after any same-cycle pop) and ufm_ready=1, go to ISSUE.
- ISSUE:
  - ufm_start=1 for exactly one cycle.
  - ufm_page_addr = first_page + page_idx, modulo 2048 (11-bit wrap: 0x7FF+1 → 0x000).
  - Clear byte_cnt; go to COLLECT.
- COLLECT:
  - Each ufm_rd_stb pushes ufm_data_rd into the FIFO and increments byte_cnt.
  - On the 16th strobe, go to WAIT_IDLE. Push of that byte happens the same edge.
- WAIT_IDLE: when ufm_ready=1, page_idx++.
  - If page_idx == num_pages, go to DRAIN.
  - Otherwise go to WAIT_SPACE.
- DRAIN: when FIFO empty, pulse done, drop busy, return to IDLE. done and busy deassert coincide.
- ufm_rd_stb outside COLLECT: ignored; no FIFO write.
- FIFO:
  - Synchronous, registered output; first-word latency 1 cycle from push to m_valid.
  - Pop when m_valid && m_ready.
  - Simultaneous push and pop: count unchanged, including at full or empty.
  - Overflow is impossible by the space check. Push while full is dropped (defensive).
- m_valid depends only on FIFO non-empty. Data is held stable while m_valid && !m_ready.
- go while busy: ignored.

Optional Feature:
- Macro: UFM_PAGE_FETCHER_LAST_EN.
- Defined:
  - Adds output port m_last (1 bit), stored in the FIFO as a 9th bit.
  - m_last=1 on the 16th byte of the final page of a run, and on that byte only.
- Undefined:
  - Port absent; FIFO 8 bits wide.
  - All other behaviour identical.

Decomposition:
- Package ufm_pkg holds:
  - fetcher state encoding (localparams);
  - UFM_PAGE_ADDR_W=11;
  - UFM_PAGE_BYTES=16;
  - UFM_MAX_PAGES=2048.
- One sub-module: ufm_byte_fifo (parameterised width/depth sync FIFO with count output).

Test Plan:
- Single page: first_page=0x005, num_pages=1, streamer model emits bytes 0x00..0x0F, m_ready=1 → one ufm_start with addr 0x005; m_data 0x00..0x0F in order; done pulses after last pop; m_last only on 0x0F.
- Wrap: first_page=0x7FE, num_pages=3 → ufm_page_addr sequence 0x7FE, 0x7FF, 0x000; 48 bytes out.
- Backpressure: FIFO_DEPTH=32, num_pages=4, m_ready=0 → exactly 2 ufm_start pulses, then stall in WAIT_SPACE with FIFO count=32. Release m_ready → remaining 2 pages issued; 64 bytes total, no loss.
- num_pages=0 → done pulses 1 cycle after go; busy never high; no ufm_start.
- Stray ufm_rd_stb in IDLE with data 0xAA → FIFO stays empty; m_valid stays 0.
- Assert rst low during COLLECT of page 2 of 3 → next cycle busy=0, m_valid=0, no done. A new go then restarts cleanly from first_page.
